crack: RTL and testbench
========================

# crack

Key-search controller for the ARC4 decryption datapath. It steps a 24-bit key candidate through a configurable range and, for each candidate, runs one complete decryption on an external arc4 engine. It then scans the resulting plaintext memory and stops at the first key whose plaintext is fully printable. On the arc4 en/rdy handshake it is the initiating side, and it is the reader of the plaintext memory that arc4 writes.

## Interface
Parameters:
- KEY_START, 24'h000000, first candidate key.
- KEY_LAST, 24'hFFFFFF, last candidate key (inclusive).
- KEY_STEP, 24'h000001, candidate increment; nonzero.

Ports:
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  start request; sampled only while rdy=1.
- rdy  out  1  high when idle and able to accept en.
- key  out  24  found key; valid when key_valid=1.
- key_valid  out  1  search result: 1 = key found, 0 = range exhausted.
- a4_en  out  1  arc4 start pulse.
- a4_rdy  in  1  arc4 ready.
- a4_key  out  24  candidate key presented to arc4; held stable while arc4 is busy.
- pt_addr  out  8  plaintext memory read address.
- pt_rddata  in  8  plaintext read data; synchronous RAM, valid 1 cycle after pt_addr.

## Operation
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RD_LEN, CHK_LEN, RD_CHAR, CHK_CHAR, NEXT, DONE.
- IDLE:
  - rdy=1.
  - On en, load cand=KEY_START, clear key_valid, go to LAUNCH.
- LAUNCH:
  - a4_key=cand.
  - a4_en=1 only while a4_rdy=1; on that cycle go to WAIT_BUSY. Otherwise hold.
- WAIT_BUSY: wait for a4_rdy=0. This rejects the stale ready level that arc4 still shows in the cycle after it samples en.
- WAIT_DONE: wait for a4_rdy=1, then go to RD_LEN.
- RD_LEN: pt_addr=0. pt[0] holds the message length L.
- CHK_LEN:
  - Latch L. Set idx=1.
  - If L=0, the candidate is accepted and the FSM goes to DONE with a hit.
- RD_CHAR / CHK_CHAR:
  - pt_addr=idx; check the byte in the next cycle.
  - A byte is printable if 8'h20 ≤ b ≤ 8'h7E, inclusive.
  - Non-printable byte: abort immediately and go to NEXT.
  - Printable byte with idx=L: hit, go to DONE.
  - Otherwise idx+1, back to RD_CHAR.
- NEXT:
  - Compute nxt = cand + KEY_STEP in 25 bits.
  - If nxt > KEY_LAST or nxt[24]=1, go to DONE with a miss.
  - Otherwise cand=nxt and go to LAUNCH.
- DONE:
  - Hit: key=cand, key_valid=1.
  - Miss: key=0, key_valid=0.
  - rdy=0 for this one cycle, then go to IDLE.
- key and key_valid hold their values in IDLE until the next accepted en, which clears key_valid at that edge.
- en is ignored whenever rdy=0.

## Timing
- Reset values:
  - rdy=1, key=0, key_valid=0, a4_en=0, a4_key=0, pt_addr=0.
  - State = IDLE, cand=0.
- Reset mid-search takes effect immediately (asynchronous): outputs return to their reset values and a4_en is never left asserted. The arc4 engine is reset by the same rst_n.
- en accepted at edge N: a4_en is high no earlier than cycle N+1.
- a4_en is high for exactly one cycle per candidate.
- a4_key changes only in NEXT, never between a4_en and the return of a4_rdy.
- Per-candidate scan overhead after arc4 completes: 2 cycles for the length, plus 2 cycles per byte checked, plus 1 cycle in NEXT.
- Results are registered: key and key_valid update on the edge that leaves DONE.
- pt_addr is driven only in RD_* states; it is 0 otherwise.

## Configuration
- CRACK_TRIED_CNT_EN, defined:
  - Adds output port tried[24:0].
  - Cleared on accepted en; incremented once per a4_en pulse.
  - Holds its final count through DONE and IDLE. Reset value is 0.
- CRACK_TRIED_CNT_EN, undefined: no port, no counter logic.

## Test plan
- Behavioural arc4 model that writes a printable plaintext (L=5) only for key 3; KEY_START=0 -> key=24'h000003, key_valid=1, exactly 4 a4_en pulses, tried=4 when the macro is defined.
- No accepted key, KEY_LAST=7 -> 8 pulses, then DONE with key=0, key_valid=0, and rdy back to 1 one cycle after DONE.
- Model writes L=0 for every key -> KEY_START accepted after the first arc4 run, no RD_CHAR reads issued.
- Boundary bytes:
  - Last byte 8'h20 or 8'h7E -> accepted.
  - Last byte 8'h1F or 8'h7F -> rejected, next candidate launched.
  - Byte 8'h00 at idx=1 -> abort after a single char read.
- KEY_START=24'hFFFFFD, KEY_STEP=2, no hit -> candidates FFFFFD, FFFFFF only; no wrap to 1; miss reported.
- rst_n pulsed low during WAIT_DONE -> rdy=1, a4_en=0, key_valid=0 immediately; a new en restarts from KEY_START.

Source files
------------

// File: rtl/crack.sv
// ARC4 key-search controller: launches arc4 per candidate key and scans the plaintext for printability.
// Optional CRACK_TRIED_CNT_EN adds a 25-bit count of candidates launched on port tried.
module crack #(
    parameter logic [23:0] KEY_START = 24'h000000,
    parameter logic [23:0] KEY_LAST  = 24'hFFFFFF,
    parameter logic [23:0] KEY_STEP  = 24'h000001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        rdy,
    output logic [23:0] key,
    output logic        key_valid,
    output logic        a4_en,
    input  logic        a4_rdy,
    output logic [23:0] a4_key,
    output logic [7:0]  pt_addr,
    input  logic [7:0]  pt_rddata
`ifdef CRACK_TRIED_CNT_EN
    ,
    output logic [24:0] tried
`endif
);

    typedef enum logic [3:0] {
        S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_WAIT_DONE, S_RD_LEN,
        S_CHK_LEN, S_RD_CHAR, S_CHK_CHAR, S_NEXT, S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [23:0] cand_q, cand_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  idx_q, idx_d;
    logic        hit_q, hit_d;
    logic [23:0] key_q, key_d;
    logic        key_valid_q, key_valid_d;
    logic [24:0] nxt;
    logic        printable;

    assign nxt       = {1'b0, cand_q} + {1'b0, KEY_STEP};
    assign printable = (pt_rddata >= 8'h20) && (pt_rddata <= 8'h7E);

    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign a4_key    = cand_q;

`ifdef CRACK_TRIED_CNT_EN
    logic [24:0] tried_q, tried_d;
    assign tried = tried_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tried_q <= '0;
        end else begin
            tried_q <= tried_d;
        end
    end

    always_comb begin
        tried_d = tried_q;
        if (state_q == S_IDLE && en) begin
            tried_d = '0;
        end else if (a4_en) begin
            tried_d = tried_q + 25'd1;
        end
    end
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cand_q      <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            hit_q       <= 1'b0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            hit_q       <= hit_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        len_d       = len_q;
        idx_d       = idx_q;
        hit_d       = hit_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        rdy         = 1'b0;
        a4_en       = 1'b0;
        pt_addr     = 8'd0;

        unique case (state_q)
            S_IDLE: begin
                rdy = 1'b1;
                if (en) begin
                    cand_d      = KEY_START;
                    key_valid_d = 1'b0;
                    hit_d       = 1'b0;
                    state_d     = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (a4_rdy) begin
                    a4_en   = 1'b1;
                    state_d = S_WAIT_BUSY;
                end
            end
            // arc4 still shows ready in the cycle after it samples en; wait for it to drop.
            S_WAIT_BUSY: begin
                if (!a4_rdy) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (a4_rdy) state_d = S_RD_LEN;
            end
            S_RD_LEN: begin
                pt_addr = 8'd0;
                state_d = S_CHK_LEN;
            end
            S_CHK_LEN: begin
                len_d = pt_rddata;
                idx_d = 8'd1;
                if (pt_rddata == 8'd0) begin
                    hit_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_RD_CHAR;
                end
            end
            S_RD_CHAR: begin
                pt_addr = idx_q;
                state_d = S_CHK_CHAR;
            end
            S_CHK_CHAR: begin
                if (!printable) begin
                    state_d = S_NEXT;
                end else if (idx_q == len_q) begin
                    hit_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = S_RD_CHAR;
                end
            end
            // 25-bit sum so a carry out of the key space ends the search instead of wrapping.
            S_NEXT: begin
                if (nxt[24] || nxt > {1'b0, KEY_LAST}) begin
                    hit_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    cand_d  = nxt[23:0];
                    state_d = S_LAUNCH;
                end
            end
            S_DONE: begin
                key_d       = hit_q ? cand_q : 24'd0;
                key_valid_d = hit_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_crack.sv
// Directed bench for crack: behavioural arc4 engines with scripted plaintext per key.
module tb_crack;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- instance A: keys 0..7 ----------------
    logic        en_a = 1'b0;
    logic        rdy_a, key_valid_a, a4_en_a, a4_rdy_a;
    logic [23:0] key_a, a4_key_a;
    logic [7:0]  pt_addr_a, pt_rd_a;
`ifdef CRACK_TRIED_CNT_EN
    logic [24:0] tried_a;
`endif

    crack #(.KEY_START(24'h0), .KEY_LAST(24'h7), .KEY_STEP(24'h1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .rdy(rdy_a), .key(key_a),
        .key_valid(key_valid_a), .a4_en(a4_en_a), .a4_rdy(a4_rdy_a),
        .a4_key(a4_key_a), .pt_addr(pt_addr_a), .pt_rddata(pt_rd_a)
`ifdef CRACK_TRIED_CNT_EN
        , .tried(tried_a)
`endif
    );

    // Mode 0: key 3 -> "Hello", else abort at idx 2. Mode 1: L=3, byte 1 = 00.
    // Mode 2: L=0.  Mode 3: L=2, last byte = bval for key 0, 'B' otherwise.
    int          mode_a = 0;
    logic [7:0]  bval = 8'h20;
    int          cnt_a;
    logic [23:0] klat_a;
    logic [7:0]  mem_a [256];
    int          pulses_a = 0, reads_a = 0, unstable_a = 0;
    logic [23:0] first_key_a;

    assign a4_rdy_a = (cnt_a == 0) || (cnt_a == 5);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a  <= 0;
            klat_a <= '0;
        end else if (cnt_a == 0 && a4_en_a) begin
            cnt_a  <= 5;
            klat_a <= a4_key_a;
        end else if (cnt_a > 0) begin
            cnt_a <= cnt_a - 1;
        end
    end

    always @(posedge clk) begin
        pt_rd_a <= mem_a[pt_addr_a];
        if (rst_n && cnt_a == 1) begin
            case (mode_a)
                0: begin
                    mem_a[0] <= 8'd5;
                    if (klat_a == 24'd3) begin
                        mem_a[1] <= 8'h48; mem_a[2] <= 8'h65; mem_a[3] <= 8'h6C;
                        mem_a[4] <= 8'h6C; mem_a[5] <= 8'h6F;
                    end else begin
                        mem_a[1] <= 8'h41; mem_a[2] <= 8'h0A;
                    end
                end
                1: begin mem_a[0] <= 8'd3; mem_a[1] <= 8'h00; end
                2: mem_a[0] <= 8'd0;
                default: begin
                    mem_a[0] <= 8'd2; mem_a[1] <= 8'h41;
                    mem_a[2] <= (klat_a == 24'd0) ? bval : 8'h42;
                end
            endcase
        end
        if (rst_n && cnt_a > 0 && a4_key_a != klat_a) unstable_a <= unstable_a + 1;
        if (clr) begin
            pulses_a <= 0;
            reads_a  <= 0;
        end else begin
            if (a4_en_a) begin
                if (pulses_a == 0) first_key_a <= a4_key_a;
                pulses_a <= pulses_a + 1;
            end
            if (pt_addr_a != 8'd0) reads_a <= reads_a + 1;
        end
    end

    // ---------------- instance B: start FFFFFD, step 2 ----------------
    logic        en_b = 1'b0;
    logic        rdy_b, key_valid_b, a4_en_b, a4_rdy_b;
    logic [23:0] key_b, a4_key_b;
    logic [7:0]  pt_addr_b, pt_rd_b;
`ifdef CRACK_TRIED_CNT_EN
    logic [24:0] tried_b;
`endif

    crack #(.KEY_START(24'hFFFFFD), .KEY_STEP(24'h2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .rdy(rdy_b), .key(key_b),
        .key_valid(key_valid_b), .a4_en(a4_en_b), .a4_rdy(a4_rdy_b),
        .a4_key(a4_key_b), .pt_addr(pt_addr_b), .pt_rddata(pt_rd_b)
`ifdef CRACK_TRIED_CNT_EN
        , .tried(tried_b)
`endif
    );

    int          cnt_b;
    int          pulses_b = 0;
    logic [23:0] keys_b [4];

    assign a4_rdy_b = (cnt_b == 0) || (cnt_b == 5);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_b <= 0;
        else if (cnt_b == 0 && a4_en_b) cnt_b <= 5;
        else if (cnt_b > 0) cnt_b <= cnt_b - 1;
    end

    // Every candidate yields L=1 with a single 7F byte: never accepted.
    always @(posedge clk) begin
        pt_rd_b <= (pt_addr_b == 8'd0) ? 8'd1 : 8'h7F;
        if (a4_en_b) begin
            if (pulses_b < 4) keys_b[pulses_b] <= a4_key_b;
            pulses_b <= pulses_b + 1;
        end
    end

    // Start instance A and wait for it to return to idle.
    task automatic run_a(input string tag);
        int n;
        @(negedge clk);
        clr  = 1'b1;
        en_a = 1'b1;
        check({tag, " a4_en before accept"}, {31'd0, a4_en_a}, 32'd0);
        @(negedge clk);
        clr  = 1'b0;
        en_a = 1'b0;
        n = 0;
        while (!rdy_a && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check({tag, " timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        #1;
        check("reset rdy", {31'd0, rdy_a}, 32'd1);
        check("reset key", {8'd0, key_a}, 32'd0);
        check("reset key_valid", {31'd0, key_valid_a}, 32'd0);
        check("reset a4_en", {31'd0, a4_en_a}, 32'd0);
        check("reset a4_key", {8'd0, a4_key_a}, 32'd0);
        check("reset pt_addr", {24'd0, pt_addr_a}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Hit on key 3.
        mode_a = 0;
        run_a("hit3");
        check("hit3 key", {8'd0, key_a}, 32'd3);
        check("hit3 valid", {31'd0, key_valid_a}, 32'd1);
        check("hit3 pulses", pulses_a, 32'd4);
        check("hit3 first key", {8'd0, first_key_a}, 32'd0);
        check("hit3 char reads", reads_a, 32'd11);
        check("hit3 a4_key stable", unstable_a, 32'd0);
`ifdef CRACK_TRIED_CNT_EN
        check("hit3 tried", {7'd0, tried_a}, 32'd4);
`endif
        repeat (5) @(negedge clk);
        check("hit3 hold key", {8'd0, key_a}, 32'd3);
        check("hit3 hold valid", {31'd0, key_valid_a}, 32'd1);

        // No accepted key: byte 00 at idx 1 for all 8 candidates.
        mode_a = 1;
        run_a("miss");
        check("miss key", {8'd0, key_a}, 32'd0);
        check("miss valid", {31'd0, key_valid_a}, 32'd0);
        check("miss pulses", pulses_a, 32'd8);
        check("miss char reads", reads_a, 32'd8);
`ifdef CRACK_TRIED_CNT_EN
        check("miss tried", {7'd0, tried_a}, 32'd8);
`endif

        // Empty message accepted at KEY_START.
        mode_a = 2;
        run_a("len0");
        check("len0 key", {8'd0, key_a}, 32'd0);
        check("len0 valid", {31'd0, key_valid_a}, 32'd1);
        check("len0 pulses", pulses_a, 32'd1);
        check("len0 char reads", reads_a, 32'd0);

        // Printable-range boundaries on the last byte.
        mode_a = 3;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] vals [4];
            logic [23:0] exp_key;
            vals = '{8'h20, 8'h7E, 8'h1F, 8'h7F};
            bval = vals[i];
            exp_key = (i < 2) ? 24'd0 : 24'd1;
            run_a($sformatf("byte%02h", bval));
            check($sformatf("byte%02h key", bval), {8'd0, key_a}, {8'd0, exp_key});
            check($sformatf("byte%02h valid", bval), {31'd0, key_valid_a}, 32'd1);
            check($sformatf("byte%02h pulses", bval), pulses_a, (i < 2) ? 32'd1 : 32'd2);
        end

        // Range end without wrap on instance B.
        @(negedge clk);
        en_b = 1'b1;
        @(negedge clk);
        en_b = 1'b0;
        for (int n = 0; n < 2000 && !rdy_b; n++) @(negedge clk);
        check("wrap rdy", {31'd0, rdy_b}, 32'd1);
        check("wrap pulses", pulses_b, 32'd2);
        check("wrap cand0", {8'd0, keys_b[0]}, 32'h00FFFFFD);
        check("wrap cand1", {8'd0, keys_b[1]}, 32'h00FFFFFF);
        check("wrap key", {8'd0, key_b}, 32'd0);
        check("wrap valid", {31'd0, key_valid_b}, 32'd0);
`ifdef CRACK_TRIED_CNT_EN
        check("wrap tried", {7'd0, tried_b}, 32'd2);
`endif

        // Reset during WAIT_DONE after a previous hit.
        mode_a = 0;
        @(negedge clk);
        en_a = 1'b1;
        @(negedge clk);
        en_a = 1'b0;
        for (int n = 0; n < 200 && a4_rdy_a; n++) @(negedge clk);
        check("rst busy seen", {31'd0, a4_rdy_a}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst rdy", {31'd0, rdy_a}, 32'd1);
        check("rst a4_en", {31'd0, a4_en_a}, 32'd0);
        check("rst key_valid", {31'd0, key_valid_a}, 32'd0);
        check("rst a4_key", {8'd0, a4_key_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_a("restart");
        check("restart first key", {8'd0, first_key_a}, 32'd0);
        check("restart pulses", pulses_a, 32'd4);
        check("restart key", {8'd0, key_a}, 32'd3);
        check("restart valid", {31'd0, key_valid_a}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
